hazard_scheduler: RTL
=====================

// Module: hazard_scheduler
// PURPOSE
// - Pipeline sequencer for the 5-stage core (IF/ID/EX/MEM/WB). Decides each cycle whether stages advance, stall, or are flushed.
// - Detects load-use hazards, taken-branch redirects and data-memory wait states.
// - Produces registered EX-stage forwarding selects, plus saturating stall/flush performance counters.
// - Sits beside the pipeline registers; drives their enable and clear inputs.
// PARAMETERS
// - REG_AW       5    register address width
// - CNT_W        16   width of perf counters (saturating)
// - MEM_TIMEOUT  255  max consecutive mem wait cycles before mem_timeout_err (0 = disabled)
// PORTS
// - clk             in   1       clock, all state updates on posedge
// - reset           in   1       synchronous, active-high
// - id_rs1, id_rs2  in   REG_AW  source regs of instr in ID
// - id_use_rs1/2    in   1       ID instr actually reads rs1/rs2
// - ex_rd           in   REG_AW  dest of instr in EX
// - ex_wen          in   1       EX instr writes rd
// - ex_is_load      in   1       EX instr is a load
// - mem_rd          in   REG_AW  dest of instr in MEM
// - mem_wen         in   1       MEM instr writes rd
// - ex_branch_taken in   1       EX resolved a taken branch/jump
// - mem_req         in   1       MEM stage has an outstanding data access
// - mem_ready       in   1       data memory completes access this cycle
// - pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out 1  stage advance enables
// - if_id_clr, id_ex_clr  out  1       insert bubble (clear valid) in that register
// - fwd_rs1, fwd_rs2      out  2       EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB, 11 unused
// - stall_cnt, flush_cnt  out  CNT_W   stall cycles / flush events, saturating
// - mem_timeout_err       out  1       sticky; set when wait exceeds MEM_TIMEOUT
// BEHAVIOUR
// Reset values:
// - All enables=1, clears=0, fwd_*=00, counters=0, mem_timeout_err=0, state=RUN, wait counter=0.
// - Reset mid-operation discards any pending stall or flush; the next cycle is RUN.
// Hazards:
// - A hazard requires rd!=0 and the matching wen.
// - Load-use: ex_is_load & ex_wen & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
// Condition priority (highest first):
// - reset > mem wait > branch flush > load-use.
// Mem wait (mem_req & !mem_ready):
// - All five enables=0 and clears=0; the whole pipe freezes.
// - stall_cnt+1 per cycle.
// - The wait counter increments; exceeding MEM_TIMEOUT sets the error flag.
// Branch flush (ex_branch_taken, no mem wait):
// - pc_en=1, if_id_clr=1, id_ex_clr=1.
// - flush_cnt+1 once per event.
// - A coincident load-use is ignored, because ID holds a wrong-path instruction.
// Load-use (no higher condition):
// - pc_en=0, if_id_en=0, id_ex_clr=1; EX onward advance.
// - Exactly one bubble cycle; stall_cnt+1.
// - The next cycle re-evaluates and finds forwarding from MEM/WB.
// FSM: RUN, LOAD_STALL, MEM_WAIT, FLUSH.
// - Outputs are a decode of the next-state conditions.
// - State is registered only for the wait counter and for event counting.
// - The counter increments on entry to FLUSH, not while in it.
// - A branch held in EX during MEM_WAIT flushes on the first cycle mem_ready=1. That cycle advances and flushes simultaneously.
// Forwarding:
// - Computed from ID operands vs ex_rd/mem_rd (EX match wins over MEM).
// - Registered on posedge when id_ex_en=1.
// - Forced to 00 when id_ex_clr=1; held when id_ex_en=0.
// - rd==0 never forwards.
// Counters:
// - Saturate at all-ones (no wrap).
// - The wait counter clears when mem_ready=1 or mem_req=0.
// STRUCTURE
// - Package fewcore_ctrl_pkg:
//   - fwd_sel_t (FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10).
//   - hz_state_t enum.
//   - REG_AW default.
// - One sub-module hazard_compare (combinational): rs/rd match producing load_use, fwd_rs1_nxt, fwd_rs2_nxt.
// - FSM, counters and output registers live in hazard_scheduler.
// TESTING
// - 1. Load-use: EX lw x5; ID add x6,x5,x1 (use_rs1) -> 1 cycle pc_en=0, if_id_en=0, id_ex_clr=1; next cycle fwd_rs1=10; stall_cnt=1.
// - 2. Load to x0: EX lw x0; ID reads x0 -> no stall, fwd_rs1=00.
// - 3. Branch + load-use same cycle: ex_branch_taken=1 and load-use -> if_id_clr=id_ex_clr=1, pc_en=1, flush_cnt=1, stall_cnt=0.
// - 4. Mem wait 3 cycles, then ready -> all enables 0 for 3 cycles, stall_cnt=3, then enables 1; a branch held in EX flushes on the ready cycle.
// - 5. MEM_TIMEOUT=4, mem_ready held 0 for 6 cycles -> mem_timeout_err=1 from the cycle after wait count exceeds 4; it stays set until reset.
// - 6. Double forward: EX add x7, MEM add x7, ID reads x7 on rs1 and rs2 -> fwd_rs1=fwd_rs2=01.
// - 7. Reset asserted during MEM_WAIT -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/fewcore_ctrl_pkg.sv
// fewcore_ctrl_pkg: shared types and defaults for the pipeline hazard control
package fewcore_ctrl_pkg;
  localparam int REG_AW_DEFAULT = 5;
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;
  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    MEM_WAIT,
    FLUSH
  } hz_state_t;
endpackage

// File: rtl/hazard_compare.sv
// hazard_compare: register match logic for load-use detection and EX operand forwarding selects
module hazard_compare
  import fewcore_ctrl_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wen,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wen,
  output logic              load_use,
  output fwd_sel_t          fwd_rs1_nxt,
  output fwd_sel_t          fwd_rs2_nxt
);
  logic ex_w, mem_w, ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  assign ex_w = ex_wen && ex_rd != '0;
  assign mem_w = mem_wen && mem_rd != '0;
  assign ex_hit1 = ex_w && id_rs1 == ex_rd;
  assign ex_hit2 = ex_w && id_rs2 == ex_rd;
  assign mem_hit1 = mem_w && id_rs1 == mem_rd;
  assign mem_hit2 = mem_w && id_rs2 == mem_rd;
  assign load_use = ex_is_load && ((id_use_rs1 && ex_hit1) || (id_use_rs2 && ex_hit2));
  assign fwd_rs1_nxt = ex_hit1 ? FWD_EXMEM : mem_hit1 ? FWD_MEMWB : FWD_RF;
  assign fwd_rs2_nxt = ex_hit2 ? FWD_EXMEM : mem_hit2 ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: 5-stage pipeline stall/flush sequencer with registered forwarding and perf counters
module hazard_scheduler
  import fewcore_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEFAULT,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wen,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_wen,
  input  logic              ex_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_clr,
  output logic              id_ex_clr,
  output logic [1:0]        fwd_rs1,
  output logic [1:0]        fwd_rs2,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              mem_timeout_err
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);
  localparam logic [WAIT_W-1:0] TMO = WAIT_W'(MEM_TIMEOUT);
  hz_state_t state_q, state_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic err_q, err_d, load_use, mem_wait;
  fwd_sel_t f1_q, f1_d, f2_q, f2_d, f1_nxt, f2_nxt;

  hazard_compare #(.REG_AW(REG_AW)) u_cmp (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_wen      (ex_wen),
    .ex_is_load  (ex_is_load),
    .mem_rd      (mem_rd),
    .mem_wen     (mem_wen),
    .load_use    (load_use),
    .fwd_rs1_nxt (f1_nxt),
    .fwd_rs2_nxt (f2_nxt)
  );

  assign mem_wait = mem_req && !mem_ready;

  always_comb begin
    state_d = reset ? RUN : mem_wait ? MEM_WAIT : ex_branch_taken ? FLUSH : load_use ? LOAD_STALL : RUN;
    pc_en = state_d != MEM_WAIT && state_d != LOAD_STALL;
    if_id_en = pc_en;
    id_ex_en = state_d != MEM_WAIT;
    ex_mem_en = id_ex_en;
    mem_wb_en = id_ex_en;
    if_id_clr = state_d == FLUSH;
    id_ex_clr = state_d == FLUSH || state_d == LOAD_STALL;
    stall_d = (!pc_en && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    flush_d = (if_id_clr && state_q != FLUSH && flush_q != '1) ? flush_q + 1'b1 : flush_q;
    wait_d = !mem_wait ? '0 : wait_q != '1 ? wait_q + 1'b1 : wait_q;
    err_d = err_q || (MEM_TIMEOUT != 0 && wait_d > TMO);
    f1_d = id_ex_clr ? FWD_RF : id_ex_en ? f1_nxt : f1_q;
    f2_d = id_ex_clr ? FWD_RF : id_ex_en ? f2_nxt : f2_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      stall_q <= '0;
      flush_q <= '0;
      wait_q <= '0;
      err_q <= 1'b0;
      f1_q <= FWD_RF;
      f2_q <= FWD_RF;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      wait_q <= wait_d;
      err_q <= err_d;
      f1_q <= f1_d;
      f2_q <= f2_d;
    end
  end

  assign fwd_rs1 = f1_q;
  assign fwd_rs2 = f2_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
  assign mem_timeout_err = err_q;
endmodule
